// File: rtl/serial_pkg.sv
// Shared types and constants for the serial_collector receiver.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;
    // Parity bit, when present, arrives right after the last data bit.
    localparam int PARITY_POS    = DEFAULT_WIDTH;

    typedef enum logic {
        DATA = 1'b0,
        PAR  = 1'b1
    } state_t;

endpackage

// File: rtl/serial_bit_counter.sv
// Modulo-WIDTH bit counter with synchronous clear and enable; tc flags the last bit of a word.
module serial_bit_counter
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic Clk,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CW-1:0] count;

    always_ff @(posedge Clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (tc) count <= '0;
            else    count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_collector.sv
// Serial-in, parallel-out receiver (LSB first) with a valid/ready holding register.
// Optional even-parity bit per frame when PARITY_EN is defined.
//
// state | meaning
// DATA  | collecting data bits
// PAR   | awaiting the parity bit (PARITY_EN only)
module serial_collector
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             SerialIn,
    input  logic             BitValid,
    input  logic             Flush,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutData,
    output logic             OutValid,
    output logic             Overflow,
    output logic             ParityErr
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr, sr_next, word;
    logic             bit_acc, data_acc, tc, frame_done, hold_free;

    // Flush wins over a bit presented on the same edge.
    assign bit_acc   = BitValid && !Flush;
    assign data_acc  = bit_acc && (state_q == DATA);
    assign sr_next   = {SerialIn, sr[WIDTH-1:1]};
    assign hold_free = !OutValid || OutReady;

    serial_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .Clk    (Clk),
        .clear  (Reset || Flush),
        .enable (data_acc),
        .tc     (tc)
    );

`ifdef PARITY_EN
    logic par_err_d;

    assign frame_done = bit_acc && (state_q == PAR);
    assign word       = sr;
    assign par_err_d  = (^sr) ^ SerialIn;

    always_comb begin
        state_d = state_q;
        if (Flush) begin
            state_d = DATA;
        end else if (bit_acc) begin
            case (state_q)
                DATA:    if (tc) state_d = PAR;
                PAR:     state_d = DATA;
                default: state_d = DATA;
            endcase
        end
    end
`else
    assign frame_done = data_acc && tc;
    assign word       = sr_next;
    assign ParityErr  = 1'b0;

    always_comb begin
        state_d = DATA;
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= DATA;
        else       state_q <= state_d;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sr       <= '0;
            OutData  <= '0;
            OutValid <= 1'b0;
            Overflow <= 1'b0;
`ifdef PARITY_EN
            ParityErr <= 1'b0;
`endif
        end else begin
            if (data_acc) sr <= sr_next;
            if (OutValid && OutReady) OutValid <= 1'b0;
            if (frame_done) begin
                if (hold_free) begin
                    OutData  <= word;
                    OutValid <= 1'b1;
`ifdef PARITY_EN
                    ParityErr <= par_err_d;
`endif
                end else begin
                    Overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_collector.sv
// Directed self-checking bench for serial_collector (default build, or with PARITY_EN).
module tb_serial_collector;

    logic       Clk = 1'b0;
    logic       Reset, SerialIn, BitValid, Flush, OutReady;
    logic [7:0] OutData;
    logic       OutValid, Overflow, ParityErr;

    int checks = 0;
    int errors = 0;

    serial_collector #(.WIDTH(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .SerialIn  (SerialIn),
        .BitValid  (BitValid),
        .Flush     (Flush),
        .OutReady  (OutReady),
        .OutData   (OutData),
        .OutValid  (OutValid),
        .Overflow  (Overflow),
        .ParityErr (ParityErr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        SerialIn = b;
        BitValid = 1'b1;
        tick();
        BitValid = 1'b0;
    endtask

    // Sends one full frame; OutReady is rdy for all bits but the last, rdy_last on the last.
    task automatic send_word(input logic [7:0] w, input logic rdy, input logic rdy_last,
                             input logic par_flip);
`ifdef PARITY_EN
        OutReady = rdy;
        for (int i = 0; i < 8; i++) send_bit(w[i]);
        OutReady = rdy_last;
        send_bit((^w) ^ par_flip);
`else
        OutReady = rdy;
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        OutReady = rdy_last;
        send_bit(w[7]);
        if (par_flip) OutReady = rdy_last;
`endif
    endtask

    task automatic idle;
        BitValid = 1'b0;
        tick();
    endtask

    initial begin
        logic [8:0] fr;
        int         nb;

        Reset = 1'b1; SerialIn = 1'b0; BitValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        chk("rst_data",  OutData,   8'h00);
        chk("rst_valid", OutValid,  1'b0);
        chk("rst_ovf",   Overflow,  1'b0);
        chk("rst_perr",  ParityErr, 1'b0);

        // 0xA5 LSB first: 1,0,1,0,0,1,0,1
        fr = {1'b0, 8'hA5};
`ifdef PARITY_EN
        nb = 9;
`else
        nb = 8;
`endif
        OutReady = 1'b1;
        for (int i = 0; i < nb; i++) begin
            send_bit(fr[i]);
            if (i < nb - 1) chk("a5_early_valid", OutValid, 1'b0);
        end
        chk("a5_data",  OutData,  8'hA5);
        chk("a5_valid", OutValid, 1'b1);
        chk("a5_perr",  ParityErr, 1'b0);
        idle();
        chk("a5_one_cycle", OutValid, 1'b0);

        // Overflow: second word dropped while the first is held
        send_word(8'h3C, 1'b0, 1'b0, 1'b0);
        chk("ov_first_data",  OutData,  8'h3C);
        chk("ov_first_valid", OutValid, 1'b1);
        chk("ov_first_ovf",   Overflow, 1'b0);
        send_word(8'h81, 1'b0, 1'b0, 1'b0);
        chk("ov_hold_data",  OutData,  8'h3C);
        chk("ov_hold_valid", OutValid, 1'b1);
        chk("ov_sticky",     Overflow, 1'b1);
        // Flush alone must not disturb the holding register
        Flush = 1'b1; tick(); Flush = 1'b0;
        chk("flush_keeps_valid", OutValid, 1'b1);
        chk("flush_keeps_ovf",   Overflow, 1'b1);
        OutReady = 1'b1;
        idle();
        chk("ov_drain_valid", OutValid, 1'b0);
        chk("ov_stays",       Overflow, 1'b1);

        // Partial frame + flush (bit on flush edge discarded)
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        Flush = 1'b1; SerialIn = 1'b1; BitValid = 1'b1;
        tick();
        Flush = 1'b0; BitValid = 1'b0;
        chk("flush_no_valid", OutValid, 1'b0);
        send_word(8'h5A, 1'b1, 1'b1, 1'b0);
        chk("flush_data",  OutData,  8'h5A);
        chk("flush_valid", OutValid, 1'b1);
        idle();

        // Reset mid-frame
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        Reset = 1'b1; tick(); Reset = 1'b0;
        chk("midrst_data",  OutData,  8'h00);
        chk("midrst_valid", OutValid, 1'b0);
        chk("midrst_ovf",   Overflow, 1'b0);
        send_word(8'hFF, 1'b1, 1'b1, 1'b0);
        chk("after_rst_data",  OutData,  8'hFF);
        chk("after_rst_valid", OutValid, 1'b1);
        idle();

        // New word completes on the same edge the held word is taken
        send_word(8'h77, 1'b0, 1'b0, 1'b0);
        chk("held_data", OutData, 8'h77);
        send_word(8'h12, 1'b0, 1'b1, 1'b0);
        chk("swap_data",  OutData,  8'h12);
        chk("swap_valid", OutValid, 1'b1);
        chk("swap_ovf",   Overflow, 1'b0);
        OutReady = 1'b1;
        idle();
        chk("swap_drain", OutValid, 1'b0);

        // Back-to-back frames, no gap between them
        OutReady = 1'b1;
        send_word(8'h0F, 1'b1, 1'b1, 1'b0);
        chk("b2b_0f", OutData, 8'h0F);
        send_word(8'hF0, 1'b1, 1'b1, 1'b0);
        chk("b2b_f0",     OutData,  8'hF0);
        chk("b2b_valid",  OutValid, 1'b1);
        chk("b2b_ovf",    Overflow, 1'b0);
        idle();

`ifdef PARITY_EN
        // Bad parity on 0xA5 (even number of ones, so parity 1 is wrong)
        send_word(8'hA5, 1'b1, 1'b1, 1'b1);
        chk("par_bad_data", OutData,   8'hA5);
        chk("par_bad_err",  ParityErr, 1'b1);
        idle();
        send_word(8'h01, 1'b1, 1'b1, 1'b0);
        chk("par_good_err", ParityErr, 1'b0);
        idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
